// File: rtl/bram_burst_master.sv
// Burst initiator for the BRAM wrapper request/valid port: turns a read or write
// burst command into single-beat accesses, one read outstanding at a time.
module bram_burst_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 31,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_HOLD = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] w_cur_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  w_remaining_nxt;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic [DATA_WIDTH-1:0] w_rdata_q_nxt;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         w_timer_nxt;
  logic                  w_last_beat;

  assign w_last_beat = (r_remaining == LEN_WIDTH'(1));

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_rdata_q   <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_rdata_q   <= w_rdata_q_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    w_rdata_q_nxt   = r_rdata_q;
    w_timer_nxt     = r_timer;
    cmd_ready       = 1'b0;
    wdata_ready     = 1'b0;
    rdata_valid     = 1'b0;
    rdata           = r_rdata_q;
    done            = 1'b0;
    error           = 1'b0;
    mem_addr        = r_cur_addr;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_din         = '0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cur_addr_nxt  = cmd_addr;
          w_remaining_nxt = cmd_len;
          if (cmd_len == '0) begin
            w_state_nxt = S_DONE;
          end else if (cmd_write) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      // Write strobe follows wdata_valid directly so beats stream one per cycle.
      S_WR: begin
        wdata_ready = 1'b1;
        mem_en      = wdata_valid;
        mem_we      = wdata_valid;
        mem_din     = wdata;
        if (wdata_valid) begin
          w_cur_addr_nxt  = r_cur_addr + ADDR_WIDTH'(1);
          w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
          w_state_nxt     = w_last_beat ? S_DONE : S_WR;
        end else begin
          w_state_nxt = S_WR;
        end
      end

      S_RD_REQ: begin
        mem_en      = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (mem_valid) begin
          w_rdata_q_nxt = mem_dout;
          w_state_nxt   = S_RD_HOLD;
        end else if (r_timer == TIMER_LAST) begin
          w_timer_nxt = r_timer + TW'(1);
          w_state_nxt = S_ERR;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
          w_state_nxt = S_RD_WAIT;
        end
      end

      S_RD_HOLD: begin
        rdata_valid = 1'b1;
        if (rdata_ready) begin
          w_cur_addr_nxt  = r_cur_addr + ADDR_WIDTH'(1);
          w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
          w_state_nxt     = w_last_beat ? S_DONE : S_RD_REQ;
        end else begin
          w_state_nxt = S_RD_HOLD;
        end
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      // Abort drops the remaining beats; a late response is ignored in IDLE.
      S_ERR: begin
        error       = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
